// File: rtl/lsu_bus_adapter.sv
// Load/store unit bus adapter: turns decoded memory-control fields into a single word-aligned
// bus transaction with byte strobes, and returns the extended load data or an error.
module lsu_bus_adapter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_load,
    input  logic            mem_wr,
    input  logic [2:0]      mem_opt,
    input  logic            mem_signed,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [1:0]      resp_cause,
    output logic            bus_valid,
    input  logic            bus_ready,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_wstrb,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] OPT_B = 3'b001;
    localparam logic [2:0] OPT_H = 3'b011;
    localparam logic [2:0] OPT_W = 3'b111;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_MISALGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2,
        RESP     = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load_q, load_d;
    logic [2:0]      opt_q, opt_d;
    logic            sign_q, sign_d;
    logic [1:0]      off_q, off_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] baddr_q, baddr_d;
    logic [3:0]      strb_q, strb_d;
    logic [XLEN-1:0] bwdata_q, bwdata_d;
    logic            rv_q, rv_d;
    logic            err_q, err_d;
    logic [1:0]      cause_q, cause_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            accept;
    logic            isOp;
    logic            illegal;
    logic            misaligned;
    logic [3:0]      reqStrb;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] loadData;

    assign accept     = req_valid && (state_q == IDLE);
    assign isOp       = mem_load || mem_wr;
    assign illegal    = (mem_load && mem_wr) || !(mem_opt inside {OPT_B, OPT_H, OPT_W});
    assign misaligned = ((mem_opt == OPT_H) && addr[0]) ||
                        ((mem_opt == OPT_W) && (addr[1:0] != 2'b00));

    always_comb begin
        reqStrb = 4'b1111;
        case (mem_opt)
            OPT_B:   reqStrb = 4'b0001 << addr[1:0];
            OPT_H:   reqStrb = 4'b0011 << addr[1:0];
            default: reqStrb = 4'b1111;
        endcase
    end

    // The bus returns the whole word; bring the addressed lane down to bit 0 before extending.
    assign rshift = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        loadData = bus_rdata;
        case (opt_q)
            OPT_B:   loadData = {{(XLEN-8){sign_q & rshift[7]}}, rshift[7:0]};
            OPT_H:   loadData = {{(XLEN-16){sign_q & rshift[15]}}, rshift[15:0]};
            default: loadData = bus_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_d   = load_q;
        opt_d    = opt_q;
        sign_d   = sign_q;
        off_d    = off_q;
        we_d     = we_q;
        baddr_d  = baddr_q;
        strb_d   = strb_q;
        bwdata_d = bwdata_q;
        rv_d     = 1'b0;
        err_d    = 1'b0;
        cause_d  = CAUSE_NONE;
        rdata_d  = '0;

        case (state_q)
            IDLE: begin
                if (accept && isOp) begin
                    load_d = mem_load;
                    opt_d  = mem_opt;
                    sign_d = mem_signed;
                    off_d  = addr[1:0];
                    if (illegal) begin
                        state_d = RESP;
                        rv_d    = 1'b1;
                        err_d   = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (misaligned) begin
                        state_d = RESP;
                        rv_d    = 1'b1;
                        err_d   = 1'b1;
                        cause_d = CAUSE_MISALGN;
                    end else begin
                        state_d  = BUS_REQ;
                        cnt_d    = '0;
                        we_d     = mem_wr;
                        baddr_d  = {addr[XLEN-1:2], 2'b00};
                        strb_d   = reqStrb;
                        bwdata_d = wdata << {addr[1:0], 3'b000};
                    end
                end
            end
            // A handshake in the final allowed cycle still counts; the bus has seen it.
            BUS_REQ: begin
                if (bus_ready) begin
                    state_d = BUS_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BUS_WAIT: begin
                if (bus_rvalid) begin
                    state_d = RESP;
                    rv_d    = 1'b1;
                    rdata_d = load_q ? loadData : '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            opt_q    <= 3'b000;
            sign_q   <= 1'b0;
            off_q    <= 2'b00;
            we_q     <= 1'b0;
            baddr_q  <= '0;
            strb_q   <= 4'b0000;
            bwdata_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
            cause_q  <= CAUSE_NONE;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            opt_q    <= opt_d;
            sign_q   <= sign_d;
            off_q    <= off_d;
            we_q     <= we_d;
            baddr_q  <= baddr_d;
            strb_q   <= strb_d;
            bwdata_q <= bwdata_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
            cause_q  <= cause_d;
            rdata_q  <= rdata_d;
        end
    end

    // bus_valid follows the state directly so an asynchronous reset drops it at once.
    assign req_ready  = (state_q == IDLE);
    assign bus_valid  = (state_q == BUS_REQ);
    assign bus_we     = we_q;
    assign bus_addr   = baddr_q;
    assign bus_wstrb  = strb_q;
    assign bus_wdata  = bwdata_q;
    assign resp_valid = rv_q;
    assign resp_err   = err_q;
    assign resp_cause = cause_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter: a vector table of single transactions plus
// hand-written sequences for stalls, timeouts, no-ops and reset mid-transaction.
module tb_lsu_bus_adapter;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_load;
    logic        mem_wr;
    logic [2:0]  mem_opt;
    logic        mem_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_cause;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int testsRun    = 0;
    int testsFailed = 0;

    lsu_bus_adapter #(.XLEN(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_load   (mem_load),
        .mem_wr     (mem_wr),
        .mem_opt    (mem_opt),
        .mem_signed (mem_signed),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_cause (resp_cause),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        wr;
        logic [2:0]  opt;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        expBus;
        logic [31:0] expAddr;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
        int          expLat;
        logic        expErr;
        logic [1:0]  expCause;
        logic [31:0] expRdata;
    } vec_t;

    typedef struct {
        logic        gotResp;
        int          lat;
        logic        sawBus;
        logic [31:0] busAddr;
        logic [3:0]  strb;
        logic [31:0] busWdata;
        logic        we;
        logic        err;
        logic [1:0]  cause;
        logic [31:0] rdata;
        logic        nextValid;
        logic        nextErr;
    } obs_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic ld, input logic wr, input logic [2:0] opt,
                                input logic sg, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic eb, input logic [31:0] ea,
                                input logic [3:0] es, input logic [31:0] ew, input int el,
                                input logic ee, input logic [1:0] ec, input logic [31:0] er);
        vec_t v;
        v.ld = ld; v.wr = wr; v.opt = opt; v.sg = sg; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.expBus = eb; v.expAddr = ea; v.expStrb = es; v.expWdata = ew; v.expLat = el;
        v.expErr = ee; v.expCause = ec; v.expRdata = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input logic ld, input logic wr, input logic [2:0] opt,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd);
        mem_load   = ld;
        mem_wr     = wr;
        mem_opt    = opt;
        mem_signed = sg;
        addr       = a;
        wdata      = wd;
        req_valid  = 1'b1;
    endtask

    task automatic scrambleReq;
        req_valid  = 1'b0;
        mem_load   = 1'b1;
        mem_wr     = 1'b1;
        mem_opt    = 3'b000;
        mem_signed = 1'b1;
        addr       = 32'hFFFF_FFFF;
        wdata      = 32'h5A5A_5A5A;
    endtask

    // Always-ready bus model: write ack / read data arrives the cycle after the handshake.
    task automatic applyStimulus(input vec_t v, output obs_t o);
        logic hs;
        setReq(v.ld, v.wr, v.opt, v.sg, v.addr, v.wdata);
        bus_ready  = 1'b1;
        bus_rvalid = 1'b0;
        bus_rdata  = v.rdata;
        tick();
        scrambleReq();
        hs = 1'b0;
        o  = '{default: '0};
        for (int k = 1; k <= 20 && !o.gotResp; k++) begin
            bus_rvalid = hs;
            hs = 1'b0;
            #0;
            if (bus_valid && !o.sawBus) begin
                o.sawBus   = 1'b1;
                o.busAddr  = bus_addr;
                o.strb     = bus_wstrb;
                o.busWdata = bus_wdata;
                o.we       = bus_we;
            end
            if (bus_valid && bus_ready) hs = 1'b1;
            if (resp_valid) begin
                o.gotResp = 1'b1;
                o.lat     = k;
                o.err     = resp_err;
                o.cause   = resp_cause;
                o.rdata   = resp_rdata;
            end
            tick();
        end
        bus_rvalid  = 1'b0;
        o.nextValid = resp_valid;
        o.nextErr   = resp_err;
    endtask

    task automatic checkOutput(input int idx, input vec_t v, input obs_t o);
        check($sformatf("v%0d.gotResp", idx), 32'(o.gotResp), 32'd1);
        check($sformatf("v%0d.latency", idx), 32'(o.lat), 32'(v.expLat));
        check($sformatf("v%0d.err", idx), 32'(o.err), 32'(v.expErr));
        check($sformatf("v%0d.cause", idx), 32'(o.cause), 32'(v.expCause));
        check($sformatf("v%0d.rdata", idx), o.rdata, v.expRdata);
        check($sformatf("v%0d.busActivity", idx), 32'(o.sawBus), 32'(v.expBus));
        check($sformatf("v%0d.respOneCycle", idx), 32'(o.nextValid), 32'd0);
        check($sformatf("v%0d.errCleared", idx), 32'(o.nextErr), 32'd0);
        if (v.expBus) begin
            check($sformatf("v%0d.busAddr", idx), o.busAddr, v.expAddr);
            check($sformatf("v%0d.wstrb", idx), 32'(o.strb), 32'(v.expStrb));
            check($sformatf("v%0d.busWdata", idx), o.busWdata, v.expWdata);
            check($sformatf("v%0d.busWe", idx), 32'(o.we), 32'(v.wr));
        end
    endtask

    initial begin
        obs_t o;
        int   hi;
        int   respK;

        //              ld   wr   opt     sg   addr          wdata         bus_rdata     bus  expAddr       strb     expWdata      lat ee cause expRdata
        vecs[0]  = mk(1'b1, 1'b0, 3'b001, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_FF12, 1, 32'h0000_1000, 4'b1000, 32'h0,        3, 0, 2'd0, 32'hFFFF_FF80);
        vecs[1]  = mk(1'b1, 1'b0, 3'b011, 1'b0, 32'h0000_2002, 32'h0,        32'h9ABC_1234, 1, 32'h0000_2000, 4'b1100, 32'h0,        3, 0, 2'd0, 32'h0000_9ABC);
        vecs[2]  = mk(1'b1, 1'b0, 3'b111, 1'b1, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_0010, 4'b1111, 32'h0,        3, 0, 2'd0, 32'hDEAD_BEEF);
        vecs[3]  = mk(1'b1, 1'b0, 3'b001, 1'b0, 32'h0000_5001, 32'h0,        32'h1234_80FF, 1, 32'h0000_5000, 4'b0010, 32'h0,        3, 0, 2'd0, 32'h0000_0080);
        vecs[4]  = mk(1'b1, 1'b0, 3'b011, 1'b1, 32'h0000_6000, 32'h0,        32'h0000_F00D, 1, 32'h0000_6000, 4'b0011, 32'h0,        3, 0, 2'd0, 32'hFFFF_F00D);
        vecs[5]  = mk(1'b1, 1'b0, 3'b001, 1'b1, 32'h0000_7002, 32'h0,        32'h007F_0000, 1, 32'h0000_7000, 4'b0100, 32'h0,        3, 0, 2'd0, 32'h0000_007F);
        vecs[6]  = mk(1'b0, 1'b1, 3'b111, 1'b0, 32'h0000_8004, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 32'h0000_8004, 4'b1111, 32'hCAFE_F00D, 3, 0, 2'd0, 32'h0);
        vecs[7]  = mk(1'b0, 1'b1, 3'b011, 1'b0, 32'h0000_9002, 32'h0000_BEEF, 32'h1111_1111, 1, 32'h0000_9000, 4'b1100, 32'hBEEF_0000, 3, 0, 2'd0, 32'h0);
        vecs[8]  = mk(1'b0, 1'b1, 3'b001, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h2222_2222, 1, 32'h0000_3000, 4'b0010, 32'h0000_AB00, 3, 0, 2'd0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b1, 3'b111, 1'b0, 32'h0000_4002, 32'h1234_5678, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        1, 1, 2'd1, 32'h0);
        vecs[10] = mk(1'b1, 1'b0, 3'b010, 1'b0, 32'h0000_0100, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,        1, 1, 2'd2, 32'h0);
        vecs[11] = mk(1'b1, 1'b1, 3'b111, 1'b0, 32'h0000_0200, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,        1, 1, 2'd2, 32'h0);
        vecs[12] = mk(1'b1, 1'b0, 3'b011, 1'b1, 32'h0000_1001, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,        1, 1, 2'd1, 32'h0);
        vecs[13] = mk(1'b1, 1'b1, 3'b111, 1'b0, 32'h0000_0003, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,        1, 1, 2'd2, 32'h0);
        vecs[14] = mk(1'b1, 1'b0, 3'b000, 1'b0, 32'h0000_0000, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,        1, 1, 2'd2, 32'h0);

        rst_n = 1'b0; req_valid = 1'b0; mem_load = 1'b0; mem_wr = 1'b0; mem_opt = 3'b000;
        mem_signed = 1'b0; addr = '0; wdata = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        tick();
        tick();
        check("reset.reqReady", 32'(req_ready), 32'd1);
        check("reset.busValid", 32'(bus_valid), 32'd0);
        check("reset.respValid", 32'(resp_valid), 32'd0);
        check("reset.busAddr", bus_addr, 32'h0);
        check("reset.wstrb", 32'(bus_wstrb), 32'h0);
        check("reset.cause", 32'(resp_cause), 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], o);
            checkOutput(i, vecs[i], o);
        end

        // No-op request: neither load nor store.
        setReq(1'b0, 1'b0, 3'b111, 1'b0, 32'h0000_0010, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("noop.respValid", 32'(resp_valid), 32'd0);
            check("noop.busValid", 32'(bus_valid), 32'd0);
            check("noop.reqReady", 32'(req_ready), 32'd1);
            tick();
        end

        // Store held off by bus_ready for four cycles; bus fields must stay put.
        setReq(1'b0, 1'b1, 3'b001, 1'b0, 32'h0000_3001, 32'h0000_00AB);
        bus_ready = 1'b0;
        tick();
        scrambleReq();
        for (int k = 0; k < 4; k++) begin
            check("stall.busValid", 32'(bus_valid), 32'd1);
            check("stall.busAddr", bus_addr, 32'h0000_3000);
            check("stall.wstrb", 32'(bus_wstrb), 32'b0010);
            check("stall.busWdata", bus_wdata, 32'h0000_AB00);
            check("stall.busWe", 32'(bus_we), 32'd1);
            check("stall.reqReady", 32'(req_ready), 32'd0);
            tick();
        end
        bus_ready = 1'b1;
        check("stall.busValidAtReady", 32'(bus_valid), 32'd1);
        tick();
        bus_ready = 1'b0;
        bus_rvalid = 1'b1;
        check("stall.busValidAfterHs", 32'(bus_valid), 32'd0);
        check("stall.noEarlyResp", 32'(resp_valid), 32'd0);
        tick();
        bus_rvalid = 1'b0;
        check("stall.respValid", 32'(resp_valid), 32'd1);
        check("stall.respErr", 32'(resp_err), 32'd0);
        check("stall.respRdata", resp_rdata, 32'h0);
        tick();

        // Timeout while waiting for bus_ready.
        setReq(1'b1, 1'b0, 3'b111, 1'b0, 32'h0000_0100, 32'h0);
        bus_ready = 1'b0;
        tick();
        scrambleReq();
        hi = 0;
        respK = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus_valid) hi++;
            if (resp_valid && respK == 0) begin
                respK = k;
                check("toReq.err", 32'(resp_err), 32'd1);
                check("toReq.cause", 32'(resp_cause), 32'd3);
                check("toReq.busValid", 32'(bus_valid), 32'd0);
                check("toReq.reqReady", 32'(req_ready), 32'd0);
            end
            tick();
        end
        check("toReq.busValidCycles", 32'(hi), 32'd8);
        check("toReq.respCycle", 32'(respK), 32'd9);

        // Timeout while waiting for bus_rvalid.
        setReq(1'b1, 1'b0, 3'b111, 1'b0, 32'h0000_0104, 32'h0);
        bus_ready = 1'b1;
        tick();
        scrambleReq();
        respK = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) bus_ready = 1'b0;
            if (resp_valid && respK == 0) begin
                respK = k;
                check("toWait.cause", 32'(resp_cause), 32'd3);
                check("toWait.rdata", resp_rdata, 32'h0);
            end
            tick();
        end
        check("toWait.respCycle", 32'(respK), 32'd10);

        // Reset while bus_valid is high.
        setReq(1'b1, 1'b0, 3'b111, 1'b0, 32'h0000_0300, 32'h0);
        bus_ready = 1'b0;
        tick();
        scrambleReq();
        check("rstReq.busValidBefore", 32'(bus_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstReq.busValidDrop", 32'(bus_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while in BUS_WAIT, then a stray late bus_rvalid.
        setReq(1'b1, 1'b0, 3'b111, 1'b0, 32'h0000_0200, 32'h0);
        bus_ready = 1'b1;
        tick();
        scrambleReq();
        tick();
        bus_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstWait.busValid", 32'(bus_valid), 32'd0);
        check("rstWait.respValid", 32'(resp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h7777_7777;
        check("rstWait.reqReady", 32'(req_ready), 32'd1);
        tick();
        bus_rvalid = 1'b0;
        check("rstWait.lateRvalid", 32'(resp_valid), 32'd0);
        tick();
        check("rstWait.lateRvalid2", 32'(resp_valid), 32'd0);
        applyStimulus(vecs[1], o);
        checkOutput(100, vecs[1], o);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Executes one load or store per request, using the memory control fields from instruction decode (mem_load, mem_wr, mem_opt, mem_signed).
- Converts each request into a word-aligned bus transaction with byte strobes and lane-shifted write data.
- For loads, extracts the addressed byte/half/word from the returned word and zero- or sign-extends it.
- Sits between the execute stage and the data bus as the consuming end of the decoder's memory-control encoding; detects misalignment, illegal encodings and bus timeouts.

Parameters:
XLEN, 32, data/address width (strobe width fixed at 4 for XLEN=32)
TIMEOUT, 255, cycles to wait in BUS_REQ or BUS_WAIT before aborting with a timeout error

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core request valid
req_ready  out  1  high only in IDLE
mem_load  in  1  request is a load
mem_wr  in  1  request is a store
mem_opt  in  3  access mask: 001 byte, 011 half, 111 word; any other value is illegal
mem_signed  in  1  sign-extend load result (LB/LH)
addr  in  XLEN  byte address
wdata  in  XLEN  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and on error
resp_err  out  1  completion carries an error
resp_cause  out  2  0 none, 1 misaligned, 2 illegal op, 3 timeout
bus_valid  out  1  bus request valid
bus_ready  in  1  bus accepts request
bus_we  out  1  1 write, 0 read
bus_addr  out  XLEN  {addr[XLEN-1:2],2'b00}
bus_wstrb  out  4  active byte lanes (reads and writes)
bus_wdata  out  XLEN  wdata << (8*addr[1:0])
bus_rvalid  in  1  read data / write ack valid
bus_rdata  in  XLEN  read data

Behaviour:
- States: IDLE, BUS_REQ, BUS_WAIT, RESP.
- Reset (async on rst_n low):
  - State goes to IDLE; resp_valid, resp_err, resp_cause, resp_rdata, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata and the timeout counter all go to 0.
  - req_ready = 1 while in IDLE.
  - Reset mid-transaction abandons it: bus_valid drops immediately and no response is produced.
- Accept: req_valid && req_ready.
  - Request fields are captured at the accept edge; later changes on the inputs are ignored.
  - mem_load = mem_wr = 0: no-op, state stays IDLE, no response.
- Error checks at accept, in priority order:
  - Illegal op: mem_load && mem_wr, or mem_opt not in {001, 011, 111} → cause 2.
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] ≠ 0 → cause 1.
  - On error: go to RESP with resp_err = 1; no bus activity.
- Otherwise go to BUS_REQ.
- bus_wstrb:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- BUS_REQ:
  - bus_valid = 1; bus_we, bus_addr, bus_wstrb, bus_wdata are held stable until bus_ready.
  - On bus_valid && bus_ready: go to BUS_WAIT, bus_valid = 0 next cycle.
- BUS_WAIT:
  - On bus_rvalid, go to RESP.
  - Loads: data = bus_rdata >> (8*addr[1:0]), truncated to the access size. If mem_signed, extend from bit 7 (byte) or bit 15 (half); else zero-extend. Word loads are unchanged.
  - Stores: bus_rvalid is the write acknowledge; resp_rdata = 0.
- bus_rvalid is ignored in IDLE, BUS_REQ and RESP.
- Timeout counter:
  - Cleared on entry to BUS_REQ and on entry to BUS_WAIT; increments every cycle in those states.
  - When it reaches TIMEOUT: bus_valid drops, go to RESP with cause 3.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_* fields are valid only while resp_valid = 1 and are cleared to 0 otherwise.
- Minimum latency, accept at edge N:
  - bus_valid high in cycle N+1; with bus_ready in N+1 and bus_rvalid in N+2, resp_valid is high in N+3.
  - Error path: resp_valid in N+1.
- Throughput: at most one outstanding transaction; next accept no earlier than the cycle after resp_valid.

Test Plan:
- LB, addr=0x1003, mem_opt=001, mem_signed=1, bus_rdata=0x80FF_FF12 → bus_addr=0x1000, wstrb=1000, resp_rdata=0xFFFF_FF80, resp_valid exactly 3 cycles after accept.
- LHU, addr=0x2002, mem_opt=011, mem_signed=0, bus_rdata=0x9ABC_1234 → wstrb=1100, resp_rdata=0x0000_9ABC.
- SB, addr=0x3001, wdata=0x0000_00AB; bus_ready low for 4 cycles → bus_wdata=0x0000_AB00, wstrb=0010; bus_* stable while stalled; resp_valid, err=0, rdata=0.
- SW at 0x4002 → resp_err=1, cause=1, bus_valid never asserts. mem_opt=010 → cause 2. mem_load=mem_wr=1 → cause 2.
- TIMEOUT=8, load with bus_ready held low → bus_valid drops after 8 cycles; resp_err=1, cause=3.
- rst_n pulsed low while in BUS_WAIT → bus_valid=0 and resp_valid=0 immediately; req_ready=1 after release; late bus_rvalid ignored; next request completes normally.
